// File: rtl/i2s_tx_defines.sv
// Shared I2S definitions: channel encoding, receiver state encoding and default word width.
package i2s_tx_defines;
    typedef enum logic {I2S_LEFT = 1'b0, I2S_RIGHT = 1'b1} i2s_chan_e;
    typedef enum logic [1:0] {RX_IDLE, RX_HUNT, RX_RECV, RX_DONE} i2s_rx_state_e;
    localparam int I2S_RX_DATA_WIDTH = 24;
endpackage

// File: rtl/i2s_rx_edge_sync.sv
// Brings sclk/lrclk/sdata into the aud_mclk domain and produces a one-cycle sclk rise pulse
// together with the ws/sd values sampled at that rise.
module i2s_rx_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic aud_mclk,
    input  logic aud_mrst,
    input  logic sclk_in,
    input  logic lrclk_in,
    input  logic sdata_in,
    output logic sclk_rise,
    output logic ws,
    output logic sd
);
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] ws_sync;
    logic [SYNC_STAGES-1:0] sd_sync;
    logic                   sclk_prev;

    // ws/sd are registered alongside the rise pulse so all three stay cycle-aligned
    always_ff @(posedge aud_mclk or posedge aud_mrst) begin
        if (aud_mrst) begin
            sclk_sync <= '0;
            ws_sync   <= '0;
            sd_sync   <= '0;
            sclk_prev <= 1'b0;
            sclk_rise <= 1'b0;
            ws        <= 1'b0;
            sd        <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_in};
            ws_sync   <= {ws_sync[SYNC_STAGES-2:0], lrclk_in};
            sd_sync   <= {sd_sync[SYNC_STAGES-2:0], sdata_in};
            sclk_prev <= sclk_sync[SYNC_STAGES-1];
            sclk_rise <= sclk_sync[SYNC_STAGES-1] & ~sclk_prev;
            ws        <= ws_sync[SYNC_STAGES-1];
            sd        <= sd_sync[SYNC_STAGES-1];
        end
    end
endmodule

// File: rtl/i2s_rx_deserializer.sv
// I2S receiver: rebuilds left/right PCM words from an oversampled I2S bus and presents them
// on a stream master port, with sticky overflow and short-frame status.
//   state   | meaning
//   IDLE    | disabled, partial word dropped
//   HUNT    | waiting for the first word-select change after the priming rise
//   RECV    | shifting data bits of the current slot
//   DONE    | word complete, ignoring slot padding until next word-select change
module i2s_rx_deserializer
    import i2s_tx_defines::*;
#(
    parameter int DATA_WIDTH  = I2S_RX_DATA_WIDTH,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  aud_mclk,
    input  logic                  aud_mrst,
    input  logic                  enable,
    input  logic                  sclk_in,
    input  logic                  lrclk_in,
    input  logic                  sdata_in,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tid,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  ovf_sts,
    output logic                  short_sts,
    output logic                  irq,
    input  logic                  irq_clr
);
    localparam int                CNT_W    = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    i2s_rx_state_e         state, state_nxt;
    logic                  sclk_rise, ws, sd, ws_edge;
    logic                  ws_prev, primed, push_req, push_ok;
    logic                  do_shift, do_restart, set_short, word_done;
    logic [CNT_W-1:0]      cnt;
    logic [DATA_WIDTH-1:0] shift_reg;
    i2s_chan_e             chan;

    i2s_rx_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .aud_mclk  (aud_mclk),
        .aud_mrst  (aud_mrst),
        .sclk_in   (sclk_in),
        .lrclk_in  (lrclk_in),
        .sdata_in  (sdata_in),
        .sclk_rise (sclk_rise),
        .ws        (ws),
        .sd        (sd)
    );

    assign ws_edge = sclk_rise & (ws != ws_prev);

    always_ff @(posedge aud_mclk or posedge aud_mrst) begin
        if (aud_mrst) state <= RX_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        do_shift   = 1'b0;
        do_restart = 1'b0;
        set_short  = 1'b0;
        word_done  = 1'b0;
        if (!enable) begin
            state_nxt = RX_IDLE;
        end else begin
            case (state)
                RX_IDLE: state_nxt = RX_HUNT;
                RX_HUNT: if (ws_edge && primed) begin
                    state_nxt  = RX_RECV;
                    do_restart = 1'b1;
                end
                RX_RECV: if (ws_edge) begin
                    do_restart = 1'b1;
                    set_short  = 1'b1;
                end else if (sclk_rise) begin
                    do_shift = 1'b1;
                    if (cnt == CNT_LAST) begin
                        word_done = 1'b1;
                        state_nxt = RX_DONE;
                    end
                end
                RX_DONE: if (ws_edge) begin
                    state_nxt  = RX_RECV;
                    do_restart = 1'b1;
                end
                default: state_nxt = RX_IDLE;
            endcase
        end
    end

    // The edge-coincident bit is the previous word's LSB, so it is never shifted in
    always_ff @(posedge aud_mclk or posedge aud_mrst) begin
        if (aud_mrst) begin
            ws_prev   <= 1'b0;
            primed    <= 1'b0;
            cnt       <= '0;
            shift_reg <= '0;
            chan      <= I2S_LEFT;
            push_req  <= 1'b0;
        end else begin
            if (sclk_rise && state != RX_IDLE) ws_prev <= ws;
            if (state == RX_IDLE) primed <= 1'b0;
            else if (sclk_rise)   primed <= 1'b1;
            if (!enable || do_restart) cnt <= '0;
            else if (do_shift)         cnt <= cnt + 1'b1;
            if (do_restart) chan <= i2s_chan_e'(ws);
            if (do_shift)   shift_reg <= {shift_reg[DATA_WIDTH-2:0], sd};
            push_req <= word_done;
        end
    end

    assign push_ok = push_req & (~m_axis_tvalid | m_axis_tready);

    always_ff @(posedge aud_mclk or posedge aud_mrst) begin
        if (aud_mrst) begin
            m_axis_tdata  <= '0;
            m_axis_tid    <= 1'b0;
            m_axis_tvalid <= 1'b0;
            ovf_sts       <= 1'b0;
            short_sts     <= 1'b0;
        end else begin
            if (push_ok) begin
                m_axis_tdata  <= shift_reg;
                m_axis_tid    <= chan;
                m_axis_tvalid <= 1'b1;
            end else if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
            ovf_sts   <= (push_req & ~push_ok) | (ovf_sts & ~irq_clr);
            short_sts <= set_short | (short_sts & ~irq_clr);
        end
    end

    assign irq = ovf_sts | short_sts;
endmodule

// File: tb/tb_i2s_rx_deserializer.sv
// Self-checking bench: drives an I2S transmitter model and compares the stream output against
// a queue of the words each complete, synchronised slot should yield.
module tb_i2s_rx_deserializer;
    localparam int DW = 24;

    logic          aud_mclk = 1'b0;
    logic          aud_mrst, enable, sclk_in, lrclk_in, sdata_in;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tid, m_axis_tvalid, m_axis_tready;
    logic          ovf_sts, short_sts, irq, irq_clr;

    int            n_checks = 0;
    int            n_errors = 0;
    logic [DW:0]   exp_q[$];
    int            rdy_mode = 2;
    bit            armed = 1'b0;
    bit            cur_chan = 1'b0;
    bit            prev_short = 1'b0;
    bit            exp_short = 1'b0;

    always #5 aud_mclk = ~aud_mclk;

    i2s_rx_deserializer #(.DATA_WIDTH(DW), .SYNC_STAGES(2)) dut (
        .aud_mclk      (aud_mclk),
        .aud_mrst      (aud_mrst),
        .enable        (enable),
        .sclk_in       (sclk_in),
        .lrclk_in      (lrclk_in),
        .sdata_in      (sdata_in),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tid    (m_axis_tid),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .ovf_sts       (ovf_sts),
        .short_sts     (short_sts),
        .irq           (irq),
        .irq_clr       (irq_clr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // tready: 0 random, 1 held low, 2 held high
    initial begin
        m_axis_tready = 1'b1;
        forever begin
            @(posedge aud_mclk);
            #2;
            case (rdy_mode)
                0:       m_axis_tready = ($urandom_range(0, 3) != 0);
                1:       m_axis_tready = 1'b0;
                default: m_axis_tready = 1'b1;
            endcase
        end
    end

    initial begin
        forever begin
            @(negedge aud_mclk);
            if (m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1) begin
                if (exp_q.size() == 0) check("spurious_word", exp_q.size(), 1);
                else check("word", {m_axis_tid, m_axis_tdata}, exp_q.pop_front());
            end
        end
    end

    // One I2S slot: period 0 carries the previous LSB, then MSB..LSB, then random padding.
    // act: 1 disable at act_bit / re-enable 3 bits later, 2 async reset pulse, 3 enable.
    task automatic send_slot(input logic [DW-1:0] word, input int nbits, input int act, input int act_bit);
        bit capture;
        int low;
        cur_chan = ~cur_chan;
        capture = armed && (nbits >= DW + 1) && (act == 0);
        if (capture) exp_q.push_back({cur_chan, word});
        if (prev_short) exp_short = 1'b1;
        prev_short = armed && (nbits < DW + 1) && (act == 0);
        for (int i = 0; i < nbits; i++) begin
            lrclk_in = cur_chan;
            sdata_in = (i >= 1 && i <= DW) ? word[DW-i] : 1'($urandom_range(0, 1));
            sclk_in  = 1'b0;
            low = 40;
            if (act != 0 && i == act_bit) begin
                case (act)
                    1: enable = 1'b0;
                    2: begin
                        #3 aud_mrst = 1'b1;
                        #1;
                        check("rst_tvalid", m_axis_tvalid, 0);
                        check("rst_tdata", m_axis_tdata, 0);
                        check("rst_tid", m_axis_tid, 0);
                        check("rst_irq", irq, 0);
                        #6 aud_mrst = 1'b0;
                        exp_q.delete();
                        prev_short = 1'b0;
                        exp_short = 1'b0;
                        low = 30;
                    end
                    default: enable = 1'b1;
                endcase
                armed = 1'b1;
            end
            if (act == 1 && i == act_bit + 3) enable = 1'b1;
            #(low);
            sclk_in = 1'b1;
            #40;
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 3000 && exp_q.size() != 0; i++) @(negedge aud_mclk);
        check("drain", exp_q.size(), 0);
    endtask

    task automatic pulse_irq_clr();
        @(posedge aud_mclk);
        #2 irq_clr = 1'b1;
        @(posedge aud_mclk);
        #2 irq_clr = 1'b0;
        @(negedge aud_mclk);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] w1, w2, w3, wa;
        int            n;
        aud_mrst = 1'b0;
        enable   = 1'b0;
        sclk_in  = 1'b0;
        lrclk_in = 1'b0;
        sdata_in = 1'b0;
        irq_clr  = 1'b0;
        #1 aud_mrst = 1'b1;
        repeat (3) @(negedge aud_mclk);
        check("reset_tvalid", m_axis_tvalid, 0);
        check("reset_tdata", m_axis_tdata, 0);
        check("reset_tid", m_axis_tid, 0);
        check("reset_ovf", ovf_sts, 0);
        check("reset_short", short_sts, 0);
        check("reset_irq", irq, 0);
        @(posedge aud_mclk);
        #3 aud_mrst = 1'b0;

        // T1: enable mid-slot; that slot is lost, the following two are delivered
        send_slot(DW'($urandom), 32, 3, 5);
        send_slot(24'hA5A5A5, 25, 0, 0);
        send_slot(24'h123456, 25, 0, 0);
        wait_drain();
        check("t1_short", short_sts, 0);
        check("t1_ovf", ovf_sts, 0);

        // T2: wide slots with random padding
        rdy_mode = 0;
        send_slot(24'hFFFFFF, 32, 0, 0);
        send_slot(24'h000001, 32, 0, 0);
        wait_drain();
        check("t2_short", short_sts, 0);
        check("t2_ovf", ovf_sts, 0);

        // T3: backpressure over three words
        rdy_mode = 1;
        repeat (4) @(negedge aud_mclk);
        w1 = DW'($urandom); w2 = DW'($urandom); w3 = DW'($urandom);
        send_slot(w1, 25, 0, 0);
        send_slot(w2, 25, 0, 0);
        send_slot(w3, 25, 0, 0);
        repeat (10) @(negedge aud_mclk);
        check("t3_tvalid", m_axis_tvalid, 1);
        check("t3_tdata_held", m_axis_tdata, w1);
        check("t3_tid_held", m_axis_tid, 0);
        check("t3_ovf", ovf_sts, 1);
        check("t3_irq", irq, 1);
        void'(exp_q.pop_back());
        void'(exp_q.pop_back());
        pulse_irq_clr();
        check("t3_irq_cleared", irq, 0);
        rdy_mode = 2;
        wait_drain();
        repeat (5) @(negedge aud_mclk);
        check("t3_tvalid_once", m_axis_tvalid, 0);

        // T4: short frame then a good one
        rdy_mode = 0;
        send_slot(DW'($urandom), 25, 0, 0);
        send_slot(DW'($urandom), 21, 0, 0);
        send_slot(DW'($urandom), 25, 0, 0);
        wait_drain();
        check("t4_short", short_sts, 1);
        check("t4_irq", irq, 1);
        check("t4_ovf", ovf_sts, 0);
        pulse_irq_clr();
        check("t4_short_cleared", short_sts, 0);
        exp_short = 1'b0;

        // T5: disable mid-word while a word is held
        rdy_mode = 1;
        wa = DW'($urandom);
        send_slot(wa, 25, 0, 0);
        send_slot(DW'($urandom), 32, 1, 10);
        repeat (10) @(negedge aud_mclk);
        check("t5_tvalid", m_axis_tvalid, 1);
        check("t5_tdata_held", m_axis_tdata, wa);
        check("t5_ovf", ovf_sts, 0);
        check("t5_short", short_sts, 0);
        rdy_mode = 2;
        wait_drain();
        send_slot(DW'($urandom), 25, 0, 0);
        send_slot(DW'($urandom), 25, 0, 0);
        wait_drain();

        // T6: async reset mid-word with tvalid high, then the T1 pattern again
        rdy_mode = 1;
        send_slot(DW'($urandom), 25, 0, 0);
        repeat (10) @(negedge aud_mclk);
        check("t6_pre_tvalid", m_axis_tvalid, 1);
        send_slot(DW'($urandom), 32, 2, 12);
        rdy_mode = 2;
        send_slot(24'hA5A5A5, 25, 0, 0);
        send_slot(24'h123456, 25, 0, 0);
        wait_drain();
        check("t6_short", short_sts, 0);

        // randomized traffic: slot widths, data, padding, tready and occasional short slots
        rdy_mode = 0;
        for (int k = 0; k < 20; k++) begin
            n = ($urandom_range(0, 4) == 0 && k != 19) ? $urandom_range(22, 24) : $urandom_range(25, 32);
            send_slot(DW'($urandom), n, 0, 0);
        end
        wait_drain();
        check("rand_short", short_sts, exp_short);
        check("rand_ovf", ovf_sts, 0);
        check("rand_irq", irq, exp_short);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
